// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide unit holding the architectural HI/LO registers.
//   clk, reset    : clock and synchronous active-high reset
//   start, op     : request MULTU(00) / MULT(01) / DIVU(10) / DIV(11); sampled only in IDLE
//   a, b          : multiplicand/dividend and multiplier/divisor, latched with start
//   wr_hi, wr_lo  : MTHI / MTLO writes of wd, honoured only in IDLE without start
//   busy          : operation in progress
//   done          : one-cycle pulse; hi/lo carry the new result in that cycle
//   divzero       : last division had b==0; cleared by the next accepted start
//   hi, lo        : HI (product upper half / remainder), LO (product lower half / quotient)
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0]   ZERO  = '0;
  localparam logic [WIDTH-1:0]   ONE   = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE2  = (2*WIDTH)'(1);
  localparam logic [CW-1:0]      LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, ZDIV} state_t;

  state_t             state, state_n;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0]   dvs, dvs_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic               is_div, is_div_n;
  logic               neg_lo, neg_lo_n;
  logic               neg_hi, neg_hi_n;
  logic               busy_n, done_n, divzero_n;
  logic [WIDTH-1:0]   hi_n, lo_n;

  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step, prod;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divzero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      dvs     <= dvs_n;
      cnt     <= cnt_n;
      is_div  <= is_div_n;
      neg_lo  <= neg_lo_n;
      neg_hi  <= neg_hi_n;
      busy    <= busy_n;
      done    <= done_n;
      divzero <= divzero_n;
      hi      <= hi_n;
      lo      <= lo_n;
    end
  end

  // Next-state, datapath step and output register updates
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    dvs_n     = dvs;
    cnt_n     = cnt;
    is_div_n  = is_div;
    neg_lo_n  = neg_lo;
    neg_hi_n  = neg_hi;
    busy_n    = busy;
    done_n    = 1'b0;
    divzero_n = divzero;
    hi_n      = hi;
    lo_n      = lo;

    // Operand magnitudes for signed ops; unsigned ops pass through
    sa    = op[0] & a[WIDTH-1];
    sb    = op[0] & b[WIDTH-1];
    mag_a = sa ? (~a + ONE) : a;
    mag_b = sb ? (~b + ONE) : b;

    // Shift-add: add multiplier when the LSB of the accumulator is set, then shift right
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : {1'b0, ZERO});
    mul_step = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: the shifted partial remainder needs one extra bit
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, dvs};
    div_step = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    prod = neg_lo ? (~acc + ONE2) : acc;

    unique case (state)
      IDLE: begin
        if (start) begin
          is_div_n  = op[1];
          cnt_n     = '0;
          divzero_n = 1'b0;
          neg_lo_n  = sa ^ sb;
          neg_hi_n  = sa;
          acc_n     = {ZERO, mag_a};
          dvs_n     = mag_b;
          busy_n    = 1'b1;
          if (op[1] && (b == ZERO)) begin
            // Raw dividend is what lands in hi on divide-by-zero
            acc_n   = {ZERO, a};
            state_n = ZDIV;
          end else begin
            state_n = CALC;
          end
        end else begin
          if (wr_hi) hi_n = wd;
          if (wr_lo) lo_n = wd;
        end
      end
      CALC: begin
        acc_n = is_div ? div_step : mul_step;
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = FIX;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      FIX: begin
        if (is_div) begin
          hi_n = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + ONE) : acc[2*WIDTH-1:WIDTH];
          lo_n = neg_lo ? (~acc[WIDTH-1:0] + ONE) : acc[WIDTH-1:0];
        end else begin
          hi_n = prod[2*WIDTH-1:WIDTH];
          lo_n = prod[WIDTH-1:0];
        end
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      ZDIV: begin
        hi_n      = acc[WIDTH-1:0];
        lo_n      = '1;
        divzero_n = 1'b1;
        done_n    = 1'b1;
        busy_n    = 1'b0;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
